// File: rtl/icache_tag_ctrl.sv
// icache_tag_ctrl
//   Requester-side controller for the dual-port icache tag SRAM
//   (port 0 = write, port 1 = read). It splits each fetch address into
//   tag/index/offset, issues the tag read, and compares the returned tag
//   against a flop-based valid vector to report hit or miss. On a miss it
//   holds the line address until the refill arrives, then writes the tag.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr   fetch lookup request handshake
//   resp_valid/resp_hit        one-cycle lookup result
//   miss_valid/miss_addr       line-aligned refill request, held until fill
//   fill_valid                 refill complete pulse (honoured only in MISS)
//   flush                      invalidate every set
//   tag_csb0/addr0/din0        SRAM write port (csb active low)
//   tag_csb1/addr1/dout1       SRAM read port (dout valid the cycle after csb1=0)
module icache_tag_ctrl #(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 5,
   parameter int INDEX_W  = 4,
   localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   output logic                resp_valid,
   output logic                resp_hit,
   output logic                miss_valid,
   output logic [ADDR_W-1:0]   miss_addr,
   input  logic                fill_valid,
   input  logic                flush,
   output logic                tag_csb0,
   output logic [INDEX_W-1:0]  tag_addr0,
   output logic [TAG_W-1:0]    tag_din0,
   output logic                tag_csb1,
   output logic [INDEX_W-1:0]  tag_addr1,
   input  logic [TAG_W-1:0]    tag_dout1
);

   localparam int SETS = 1 << INDEX_W;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOOKUP = 2'd1;
   localparam logic [1:0] MISS   = 2'd2;
   localparam logic [1:0] COMMIT = 2'd3;

   logic [1:0]         state, state_nxt;
   logic [SETS-1:0]    valid;
   logic [TAG_W-1:0]   tag_q;
   logic [INDEX_W-1:0] idx_q;

   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_idx;
   logic               hit;
   logic               accept;
   logic               fill_take;

   // Offset bits never reach the tag array; only the line address matters.
   logic unused_offset;
   assign unused_offset = ^req_addr[OFFSET_W-1:0];

   assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
   assign req_idx = req_addr[OFFSET_W +: INDEX_W];

   // Compare uses the registered valid vector, so a flush arriving in the
   // LOOKUP cycle only affects lookups issued afterwards.
   assign hit = valid[idx_q] && (tag_dout1 == tag_q);

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = LOOKUP;
         end
         LOOKUP: begin
            if (hit) begin
               req_ready = 1'b1;
               state_nxt = req_valid ? LOOKUP : IDLE;
            end else begin
               state_nxt = MISS;
            end
         end
         MISS: begin
            if (fill_valid) state_nxt = COMMIT;
         end
         default: state_nxt = IDLE;  // COMMIT: SRAM write lands this cycle
      endcase
   end

   assign accept    = req_ready && req_valid;
   assign fill_take = (state == MISS) && fill_valid;

   assign resp_valid = (state == LOOKUP);
   assign resp_hit   = resp_valid && hit;
   assign miss_valid = (state == MISS);
   assign miss_addr  = {tag_q, idx_q, {OFFSET_W{1'b0}}};

   assign tag_csb1  = !accept;
   assign tag_addr1 = req_idx;
   assign tag_csb0  = !fill_take;
   assign tag_addr0 = idx_q;
   assign tag_din0  = tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         tag_q <= '0;
         idx_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            tag_q <= req_tag;
            idx_q <= req_idx;
         end
      end
   end

   // Flush has priority over a simultaneous fill: the line stays invalid
   // even though the tag write still goes out to the SRAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (fill_take) begin
         valid[idx_q] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Testbench for icache_tag_ctrl: a behavioural tag SRAM plus a table of
// per-cycle {inputs, expected outputs} vectors, followed by a hand-written
// reset-during-miss sequence. Address split used below: tag = addr[31:9],
// index = addr[8:5], so 0x1040 -> idx 2 tag 0x8, 0x1060 -> idx 3 tag 0x8,
// 0x1044 -> idx 2 tag 0x8, 0x2040 -> idx 2 tag 0x10.
module tb_icache_tag_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_hit;
   logic        miss_valid;
   logic [31:0] miss_addr;
   logic        fill_valid;
   logic        flush;
   logic        tag_csb0;
   logic [3:0]  tag_addr0;
   logic [22:0] tag_din0;
   logic        tag_csb1;
   logic [3:0]  tag_addr1;
   logic [22:0] tag_dout1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   icache_tag_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_hit(resp_hit),
      .miss_valid(miss_valid), .miss_addr(miss_addr),
      .fill_valid(fill_valid), .flush(flush),
      .tag_csb0(tag_csb0), .tag_addr0(tag_addr0), .tag_din0(tag_din0),
      .tag_csb1(tag_csb1), .tag_addr1(tag_addr1), .tag_dout1(tag_dout1)
   );

   // Tag SRAM: write captured at edge N, committed at edge N+1; read
   // address captured at an edge, data valid the following cycle.
   logic [22:0] mem [16];
   logic        pw = 1'b0;
   logic [3:0]  pa;
   logic [22:0] pd;
   always @(posedge clk) begin
      if (pw) mem[pa] <= pd;
      pw <= !tag_csb0;
      pa <= tag_addr0;
      pd <= tag_din0;
      if (!tag_csb1)
         tag_dout1 <= (pw && pa == tag_addr1) ? pd : mem[tag_addr1];
   end

   typedef struct {
      logic        rv;
      logic [31:0] ra;
      logic        fv;
      logic        fl;
      logic        rdy;
      logic        rspv;
      logic        hit;
      logic        mv;
      logic [31:0] maddr;
      logic        csb0;
      logic [3:0]  a0;
      logic [22:0] d0;
      logic        csb1;
      logic [3:0]  a1;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic rv, input logic [31:0] ra, input logic fv,
                      input logic fl, input logic rdy, input logic rspv,
                      input logic hit, input logic mv, input logic [31:0] maddr,
                      input logic csb0, input logic [3:0] a0, input logic [22:0] d0,
                      input logic csb1, input logic [3:0] a1);
      vec_t v;
      v.rv = rv; v.ra = ra; v.fv = fv; v.fl = fl;
      v.rdy = rdy; v.rspv = rspv; v.hit = hit; v.mv = mv; v.maddr = maddr;
      v.csb0 = csb0; v.a0 = a0; v.d0 = d0; v.csb1 = csb1; v.a1 = a1;
      vt.push_back(v);
   endtask

   task automatic chk(input string nm, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask

   // Shorthand rows
   task automatic idle_req(input logic [31:0] a, input logic [3:0] idx);
      add(1, a, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, idx);
   endtask
   task automatic lk_miss();
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
   endtask
   task automatic commit_row();
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 0; req_addr = 0; fill_valid = 0; flush = 0;

      // -- test 1: request 0x1040 after reset, miss
      idle_req(32'h1040, 2);
      lk_miss();
      add(0, 0, 0, 0, 0, 0, 0, 1, 32'h1040, 1, 0, 0, 1, 0);
      // held request in MISS is not consumed
      add(1, 32'h3000, 0, 0, 0, 0, 0, 1, 32'h1040, 1, 0, 0, 1, 0);
      // -- test 2: fill writes idx 2 tag 0x8
      add(0, 0, 1, 0, 0, 0, 0, 1, 32'h1040, 0, 2, 23'h8, 1, 0);
      // COMMIT: request held off, stray fill ignored
      add(1, 32'h1040, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      idle_req(32'h1040, 2);
      add(0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0);
      // -- test 3: fill idx 3, then three back-to-back hits
      idle_req(32'h1060, 3);
      lk_miss();
      add(0, 0, 1, 0, 0, 0, 0, 1, 32'h1060, 0, 3, 23'h8, 1, 0);
      commit_row();
      idle_req(32'h1040, 2);
      add(1, 32'h1060, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 3);
      add(1, 32'h1044, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 2);
      add(0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0);
      // -- test 4: same index, different tag
      idle_req(32'h2040, 2);
      lk_miss();
      add(0, 0, 1, 0, 0, 0, 0, 1, 32'h2040, 0, 2, 23'h10, 1, 0);
      commit_row();
      idle_req(32'h1040, 2);
      lk_miss();
      add(0, 0, 1, 0, 0, 0, 0, 1, 32'h1040, 0, 2, 23'h8, 1, 0);
      commit_row();
      // -- test 5: flush together with fill
      idle_req(32'h2040, 2);
      lk_miss();
      add(0, 0, 1, 1, 0, 0, 0, 1, 32'h2040, 0, 2, 23'h10, 1, 0);
      commit_row();
      idle_req(32'h2040, 2);
      lk_miss();  // tag in SRAM matches but valid was flushed
      add(0, 0, 1, 0, 0, 0, 0, 1, 32'h2040, 0, 2, 23'h10, 1, 0);
      commit_row();
      // flush during LOOKUP: this compare still sees the old valid bit
      idle_req(32'h2040, 2);
      add(0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0);
      idle_req(32'h2040, 2);
      lk_miss();
      add(0, 0, 0, 0, 0, 0, 0, 1, 32'h2040, 1, 0, 0, 1, 0);

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", -1, 32'(req_ready), 1);
      chk("rst_resp_valid", -1, 32'(resp_valid), 0);
      chk("rst_miss_valid", -1, 32'(miss_valid), 0);
      chk("rst_csb0", -1, 32'(tag_csb0), 1);
      chk("rst_csb1", -1, 32'(tag_csb1), 1);
      chk("rst_miss_addr", -1, miss_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         @(negedge clk);
         req_valid = vt[i].rv; req_addr = vt[i].ra;
         fill_valid = vt[i].fv; flush = vt[i].fl;
         #1;
         chk("req_ready", i, 32'(req_ready), 32'(vt[i].rdy));
         chk("resp_valid", i, 32'(resp_valid), 32'(vt[i].rspv));
         chk("resp_hit", i, 32'(resp_hit), 32'(vt[i].hit));
         chk("miss_valid", i, 32'(miss_valid), 32'(vt[i].mv));
         chk("tag_csb0", i, 32'(tag_csb0), 32'(vt[i].csb0));
         chk("tag_csb1", i, 32'(tag_csb1), 32'(vt[i].csb1));
         if (vt[i].mv) chk("miss_addr", i, miss_addr, vt[i].maddr);
         if (!vt[i].csb0) begin
            chk("tag_addr0", i, 32'(tag_addr0), 32'(vt[i].a0));
            chk("tag_din0", i, 32'(tag_din0), 32'(vt[i].d0));
         end
         if (!vt[i].csb1) chk("tag_addr1", i, 32'(tag_addr1), 32'(vt[i].a1));
      end

      // -- test 6: reset in the middle of MISS (DUT is in MISS for 0x2040)
      @(negedge clk);
      req_valid = 0; flush = 0; fill_valid = 1;
      rst_n = 1'b0;
      #1;
      chk("mr_req_ready", 100, 32'(req_ready), 1);
      chk("mr_resp_valid", 100, 32'(resp_valid), 0);
      chk("mr_miss_valid", 100, 32'(miss_valid), 0);
      chk("mr_csb0", 100, 32'(tag_csb0), 1);
      chk("mr_csb1", 100, 32'(tag_csb1), 1);
      chk("mr_miss_addr", 100, miss_addr, 0);
      @(negedge clk);
      chk("mr_csb0_held", 101, 32'(tag_csb0), 1);
      rst_n = 1'b1; fill_valid = 0;
      req_valid = 1; req_addr = 32'h2040;
      #1;
      chk("mr_accept_csb1", 102, 32'(tag_csb1), 0);
      chk("mr_accept_addr1", 102, 32'(tag_addr1), 2);
      @(negedge clk);
      req_valid = 0;
      #1;
      chk("mr_resp_valid2", 103, 32'(resp_valid), 1);
      chk("mr_resp_hit2", 103, 32'(resp_hit), 0);
      chk("mr_req_ready2", 103, 32'(req_ready), 0);
      @(negedge clk);
      #1;
      chk("mr_miss_valid2", 104, 32'(miss_valid), 1);
      chk("mr_miss_addr2", 104, miss_addr, 32'h2040);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
